// File: rtl/dm_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller.
package dm_access_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam bit DM_DEBUG = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_ERR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic misaligned(logic [1:0] size, logic [1:0] off);
        logic bad;
        bad = 1'b1;
        unique case (1'b1)
            size == SIZE_B: bad = 1'b0;
            size == SIZE_H: bad = off[0];
            size == SIZE_W: bad = |off;
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] be_gen(logic [1:0] size, logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        unique case (1'b1)
            size == SIZE_B: be = 4'b0001 << off;
            size == SIZE_H: be = off[1] ? 4'b1100 : 4'b0011;
            size == SIZE_W: be = 4'b1111;
            default:        be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dm_access_ctrl_lane_ext.sv
// Load lane select and sign/zero extension from raw memory word.
module dm_lane_ext
    import dm_access_ctrl_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [width-1:0] dout,
    input  logic [1:0]       off,
    input  logic [1:0]       size,
    input  logic             uns,
    output logic [width-1:0] rdata_next
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = 8'(dout >> {off, 3'b000});
        half_v     = 16'(dout >> {off[1], 4'b0000});
        rdata_next = dout;
        unique case (1'b1)
            size == SIZE_B: rdata_next = {{(width-8){~uns & byte_v[7]}}, byte_v};
            size == SIZE_H: rdata_next = {{(width-16){~uns & half_v[15]}}, half_v};
            default:        rdata_next = dout;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store initiator for the 4 KB word-addressed data memory.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int width     = 32,
    parameter int AddrWidth = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [1:0]           size,
    input  logic                 uns,
    input  logic [31:0]          addr,
    input  logic [width-1:0]     wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [width-1:0]     rdata,
    output logic [AddrWidth-1:0] dm_addr,
    output logic [3:0]           dm_be,
    output logic [width-1:0]     dm_din,
    output logic                 dm_wr,
    input  logic [width-1:0]     dm_dout
);

    state_t               state_q, state_d;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [AddrWidth+1:0] addr_q;
    logic [width-1:0]     wdata_q;
    logic [width-1:0]     rdata_q;
    logic [width-1:0]     rdata_next;
    logic [3:0]           be_q;
    logic                 err_q;
    logic                 bad;
    logic                 take;
    logic                 unused_hi;

    assign unused_hi = ^addr[31:AddrWidth+2];

    assign bad  = misaligned(size, addr[1:0]);
    assign take = (state_q == ST_IDLE) && req;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (bad)     state_d = ST_ERR;
                    else if (we) state_d = ST_WR;
                    else         state_d = ST_RD;
                end
            end
            ST_RD, ST_WR, ST_ERR: state_d = ST_DONE;
            ST_DONE:              state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            size_q  <= SIZE_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                size_q  <= size;
                uns_q   <= uns;
                addr_q  <= addr[AddrWidth+1:0];
                wdata_q <= wdata;
                err_q   <= bad;
                be_q    <= bad ? 4'b0000 : be_gen(size, addr[1:0]);
            end
            // enables only live for the single memory cycle
            if (state_q == ST_RD || state_q == ST_WR) be_q <= 4'b0000;
            if (state_q == ST_RD) rdata_q <= rdata_next;
        end
    end

    dm_lane_ext #(.width(width)) u_ext (
        .dout       (dm_dout),
        .off        (addr_q[1:0]),
        .size       (size_q),
        .uns        (uns_q),
        .rdata_next (rdata_next)
    );

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign err     = done && err_q;
    assign dm_wr   = (state_q == ST_WR);
    assign dm_be   = be_q;
    assign dm_din  = wdata_q;
    assign dm_addr = addr_q[AddrWidth+1:2];
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural data memory.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, dm_wr;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [9:0]  dm_addr;
    logic [3:0]  dm_be;

    logic [31:0] mem [0:1023];
    int n_tests = 0;
    int n_fail = 0;
    int wr_count = 0;

    always #5 clk = ~clk;

    dm_access_ctrl #(.width(32), .AddrWidth(10)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
        .uns(uns), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_din(dm_din), .dm_wr(dm_wr), .dm_dout(dm_dout)
    );

    assign dm_dout = mem[dm_addr];

    // memory picks lanes from the low-aligned din
    always @(negedge clk) begin
        if (dm_wr) begin
            wr_count++;
            for (int i = 0; i < 4; i++) begin
                if (dm_be[i]) begin
                    if (dm_be == 4'hF)
                        mem[dm_addr][8*i +: 8] <= dm_din[8*i +: 8];
                    else if (dm_be == 4'h3 || dm_be == 4'hC)
                        mem[dm_addr][8*i +: 8] <= dm_din[8*(i%2) +: 8];
                    else
                        mem[dm_addr][8*i +: 8] <= dm_din[7:0];
                end
            end
        end
    end

    task automatic access(input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a,
                          input logic [31:0] d,
                          output logic [3:0] be1, output logic wr1,
                          output logic done1, output logic done2,
                          output logic err2);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        be1 = dm_be; wr1 = dm_wr; done1 = done;
        @(posedge clk); #1;
        done2 = done; err2 = err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #2;
        n_tests++;
        if ({busy, done, err, dm_wr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 0000", {busy, done, err, dm_wr});
        end
        n_tests++;
        if (dm_be !== 4'h0 || dm_din !== 32'h0 || dm_addr !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_mem got be=%h din=%h addr=%h want 0", dm_be, dm_din, dm_addr);
        end
        n_tests++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h want 0", rdata);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_word;
        logic [3:0] be1; logic wr1, d1, d2, e2;
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, be1, wr1, d1, d2, e2);
        n_tests++;
        if ({be1, wr1, d1, d2, e2} !== {4'hF, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sw_ctl got be=%h wr=%b d1=%b d2=%b e=%b want f 1 0 1 0", be1, wr1, d1, d2, e2);
        end
        n_tests++;
        if (mem[4] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL sw_mem got %h want deadbeef", mem[4]);
        end
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, be1, wr1, d1, d2, e2);
        n_tests++;
        if ({be1, wr1, d1, d2, e2} !== {4'hF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL lw_ctl got be=%h wr=%b d1=%b d2=%b e=%b want f 0 0 1 0", be1, wr1, d1, d2, e2);
        end
        n_tests++;
        if (rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw_data got %h want deadbeef", rdata);
        end
    endtask

    task automatic test_byte;
        logic [3:0] be1; logic wr1, d1, d2, e2;
        access(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, be1, wr1, d1, d2, e2);
        n_tests++;
        if (be1 !== 4'b1000 || mem[4] !== 32'h80ADBEEF) begin
            n_fail++;
            $display("FAIL sb got be=%b mem=%h want 1000 80adbeef", be1, mem[4]);
        end
        access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, be1, wr1, d1, d2, e2);
        n_tests++;
        if (be1 !== 4'b1000 || rdata !== 32'hFFFFFF80) begin
            n_fail++;
            $display("FAIL lb got be=%b rdata=%h want 1000 ffffff80", be1, rdata);
        end
        access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, be1, wr1, d1, d2, e2);
        n_tests++;
        if (rdata !== 32'h00000080) begin
            n_fail++;
            $display("FAIL lbu got %h want 00000080", rdata);
        end
        access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, be1, wr1, d1, d2, e2);
        n_tests++;
        if (be1 !== 4'b0010 || rdata !== 32'h000000BE) begin
            n_fail++;
            $display("FAIL lbu1 got be=%b rdata=%h want 0010 000000be", be1, rdata);
        end
    endtask

    task automatic test_half;
        logic [3:0] be1; logic wr1, d1, d2, e2;
        access(1'b1, 2'b01, 1'b0, 32'h22, 32'h8001, be1, wr1, d1, d2, e2);
        n_tests++;
        if (be1 !== 4'b1100 || mem[8] !== 32'h80010000) begin
            n_fail++;
            $display("FAIL sh got be=%b mem=%h want 1100 80010000", be1, mem[8]);
        end
        access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, be1, wr1, d1, d2, e2);
        n_tests++;
        if (be1 !== 4'b1100 || rdata !== 32'hFFFF8001) begin
            n_fail++;
            $display("FAIL lh got be=%b rdata=%h want 1100 ffff8001", be1, rdata);
        end
        access(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, be1, wr1, d1, d2, e2);
        n_tests++;
        if (be1 !== 4'b0011 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL lhu got be=%b rdata=%h want 0011 0", be1, rdata);
        end
    endtask

    task automatic test_error;
        logic [3:0] be1; logic wr1, d1, d2, e2;
        int wc;
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, be1, wr1, d1, d2, e2);
        wc = wr_count;
        access(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, be1, wr1, d1, d2, e2);
        n_tests++;
        if ({be1, wr1, d1, d2, e2} !== {4'h0, 1'b0, 1'b0, 1'b1, 1'b1} || rdata !== 32'h80ADBEEF) begin
            n_fail++;
            $display("FAIL lw_mis got be=%h wr=%b d1=%b d2=%b e=%b rdata=%h want 0 0 0 1 1 80adbeef", be1, wr1, d1, d2, e2, rdata);
        end
        access(1'b1, 2'b01, 1'b0, 32'h23, 32'h5555, be1, wr1, d1, d2, e2);
        n_tests++;
        if ({be1, wr1, d2, e2} !== {4'h0, 1'b0, 1'b1, 1'b1} || mem[8] !== 32'h80010000) begin
            n_fail++;
            $display("FAIL sh_mis got be=%h wr=%b d2=%b e=%b mem=%h want 0 0 1 1 80010000", be1, wr1, d2, e2, mem[8]);
        end
        access(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, be1, wr1, d1, d2, e2);
        n_tests++;
        if ({be1, wr1, d2, e2} !== {4'h0, 1'b0, 1'b1, 1'b1} || mem[4] !== 32'h80ADBEEF) begin
            n_fail++;
            $display("FAIL size11 got be=%h wr=%b d2=%b e=%b mem=%h want 0 0 1 1 80adbeef", be1, wr1, d2, e2, mem[4]);
        end
        n_tests++;
        if (wr_count !== wc) begin
            n_fail++;
            $display("FAIL err_nowrite got %0d writes want %0d", wr_count, wc);
        end
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, be1, wr1, d1, d2, e2);
        n_tests++;
        if (rdata !== 32'h80ADBEEF || e2 !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_after_err got %h err=%b want 80adbeef 0", rdata, e2);
        end
    endtask

    task automatic test_wrap;
        logic [3:0] be1; logic wr1, d1, d2, e2;
        access(1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'h0, be1, wr1, d1, d2, e2);
        n_tests++;
        if (rdata !== 32'h80ADBEEF || dm_addr !== 10'd4) begin
            n_fail++;
            $display("FAIL wrap got rdata=%h addr=%h want 80adbeef 004", rdata, dm_addr);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] b;
        int wc;
        wc = wr_count;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'h11223344;
        @(posedge clk); #1; b[0] = busy;
        @(posedge clk); #1; b[1] = busy & done;
        @(posedge clk); #1; b[2] = busy;
        n_tests++;
        if (b[2:0] !== 3'b011 || wr_count !== wc + 1) begin
            n_fail++;
            $display("FAIL hold_req got busy=%b writes=%0d want 011 %0d", b[2:0], wr_count - wc, 1);
        end
        @(posedge clk); #1; b[3] = busy;
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (b[3] !== 1'b1 || busy !== 1'b0 || wr_count !== wc + 2 || mem[12] !== 32'h11223344) begin
            n_fail++;
            $display("FAIL reissue got busy=%b idle=%b writes=%0d mem=%h want 1 0 2 11223344", b[3], busy, wr_count - wc, mem[12]);
        end
    endtask

    task automatic test_reset_mid_wr;
        logic wr_before;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        wr_before = dm_wr;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (wr_before !== 1'b1 || dm_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wr got before=%b after=%b want 1 0", wr_before, dm_wr);
        end
        n_tests++;
        if ({busy, done, err, dm_be} !== 7'h0 || dm_din !== 32'h0 || dm_addr !== 10'h0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_outs got bde=%b be=%h din=%h addr=%h rdata=%h want 0", {busy, done, err}, dm_be, dm_din, dm_addr, rdata);
        end
        @(negedge clk); #1;
        n_tests++;
        if (mem[16] !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mem got %h want 0", mem[16]);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle got busy=%b want 0", busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_error();
        test_wrap();
        test_back_to_back();
        test_reset_mid_wr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
